evt_stream_rr_arbiter: RTL and testbench
========================================

EVT_STREAM_RR_ARBITER -- requirements
Module: evt_stream_rr_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of merged event sources (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, event beat width.
REQ-003 SHALL have parameter QUOTA_W, default 4, width of the burst quota field.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port enable_i  in  N_SRC  per-source participation mask.
REQ-007 SHALL have port synch_en_i  in  1  barrier merging on/off.
REQ-008 SHALL have port quota_i  in  QUOTA_W  maximum consecutive beats per grant, minus one.
REQ-009 SHALL have ports src_valid_i / src_ready_o  in / out  N_SRC  per-source handshake.
REQ-010 SHALL have ports src_data_i  in  N_SRC x DATA_W, and src_barrier_i  in  N_SRC  (time-step barrier marker).
REQ-011 SHALL have ports dst_valid_o / dst_ready_i  out / in  1  merged handshake.
REQ-012 SHALL have ports dst_data_o  out  DATA_W, and dst_barrier_o  out  1.
REQ-013 SHALL have ports grant_id_o  out  clog2(N_SRC)  current grantee, and busy_o  out  1  (state not IDLE or dst_valid_o high).

Function
REQ-014 SHALL implement states IDLE, GRANT, SYNC_EMIT.
REQ-015 In IDLE, on any eligible source (valid, enabled, not barrier-parked), SHALL latch the first eligible index in round-robin order from ptr and enter GRANT next cycle.
REQ-016 Round-robin ptr SHALL be set to grantee+1 (mod N_SRC) on grant release.
REQ-017 In GRANT, src_ready_o[grant] SHALL be high iff the output register is free (dst_valid_o low or dst_ready_i high); all other src_ready_o SHALL be low.
REQ-018 An accepted beat SHALL appear on dst_valid_o/dst_data_o/dst_barrier_o exactly one cycle later (registered output).
REQ-019 dst_valid_o SHALL hold, with data stable, until dst_ready_i is high.
REQ-020 Grant SHALL release to IDLE after quota_i+1 beats, when the grantee drops valid, or when enable_i[grant] goes low; one bubble cycle follows every release.
REQ-021 With synch_en_i=0, barrier beats SHALL be forwarded as ordinary beats with dst_barrier_o=1.
REQ-022 With synch_en_i=1, a barrier beat from the grantee SHALL be consumed, not forwarded, setting barrier_seen[grant] and releasing the grant; parked sources are ineligible.
REQ-023 When barrier_seen equals enable_i and enable_i is nonzero, SHALL enter SYNC_EMIT, emit one beat with dst_barrier_o=1 and dst_data_o=0 when the output register is free, clear barrier_seen, and return to IDLE.
REQ-024 barrier_seen bits of disabled sources SHALL be cleared each cycle.
REQ-025 With enable_i all zero, SHALL stay in IDLE with all src_ready_o low; an in-flight output beat SHALL still drain.
REQ-026 SYNC_EMIT SHALL take priority over new grants when both are possible in IDLE.

Reset
REQ-027 On rst_ni low: state IDLE, ptr=0, barrier_seen=0, beat count 0, dst_valid_o=0, dst_data_o=0, dst_barrier_o=0, src_ready_o=0, grant_id_o=0, busy_o=0.
REQ-028 Reset mid-transfer SHALL discard the output register contents; no beat is replayed after reset.

Configuration
REQ-029 With macro SNE_ARB_STATS_EN defined, SHALL add output stat_beats_o (N_SRC x 16), per-source accepted-beat counters that saturate at 16'hFFFF and are cleared by reset and by new input stat_clr_i.
REQ-030 Without SNE_ARB_STATS_EN, those ports and counters SHALL not exist.

Structure
REQ-031 The state enum and the default-quota constant SHALL reside in sne_evt_stream_pkg.
REQ-032 The round-robin index search SHALL be a sub-module evt_rr_pick (mask, ptr -> index, found), purely combinational.

Verification
REQ-033 N_SRC=4, enable=4'hF, quota=0, all valid, dst_ready=1 -> grant order 0,1,2,3,0, with one beat per grant and a bubble between grants.
REQ-034 quota=3, source 2 alone valid with 10 beats -> bursts of 4,4,2 with one-cycle gaps; data order preserved.
REQ-035 dst_ready_i=0 for 5 cycles mid-burst -> dst_data_o stable, src_ready_o[grant]=0, no beat lost or duplicated.
REQ-036 synch_en=1, enable=4'b0111, barriers arrive from sources 1,0,2 -> exactly one dst_barrier_o=1 beat with data 0 after the third barrier; sources 0..2 eligible again.
REQ-037 synch_en=1, sources 0,1 parked, then enable changed to 4'b0011 -> SYNC_EMIT fires in the next IDLE cycle.
REQ-038 SNE_ARB_STATS_EN defined, 70000 beats from source 3 -> stat_beats_o[3]=16'hFFFF; stat_clr_i pulse -> 0.

Source files
------------

// File: rtl/sne_evt_stream_pkg.sv
// Shared definitions for the event-stream round-robin arbiter.
//   arb_state_e  : arbiter FSM states
//   DefaultQuota : suggested burst quota (quota_i value, beats per grant minus one)
//   rr_next      : round-robin successor of an index modulo n
package sne_evt_stream_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StGrant    = 2'd1,
        StSyncEmit = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultQuota = 3;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/evt_rr_pick.sv
// Combinational round-robin search: returns the first set bit of mask_i at or after ptr_i,
// wrapping modulo N.
//   mask_i  : candidate mask
//   ptr_i   : search start index (must be < N)
//   idx_o   : selected index (0 when nothing found)
//   found_o : high when any mask bit is set
module evt_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    mask_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            found_o
);

    // One extra bit so ptr + offset (< 2N) cannot overflow before the modulo fold.
    logic [IdxW:0] j;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = {1'b0, ptr_i} + (IdxW+1)'(k);
            if (j >= (IdxW+1)'(N)) begin
                j = j - (IdxW+1)'(N);
            end
            if (!found_o && mask_i[j[IdxW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = j[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/evt_stream_rr_arbiter.sv
// Merges N_SRC valid/ready event streams into one with round-robin grants, burst quotas
// and optional time-step barrier merging.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   enable_i               : per-source participation mask
//   synch_en_i             : 1 = barrier beats are merged into one emitted barrier
//   quota_i                : max consecutive beats per grant, minus one
//   src_valid_i/ready_o    : per-source handshake; src_data_i flat N_SRC x DATA_W
//   src_barrier_i          : per-source barrier marker accompanying the beat
//   dst_valid_o/ready_i    : merged handshake; dst_data_o, dst_barrier_o registered
//   grant_id_o             : current grantee
//   busy_o                 : FSM not idle or an output beat pending
// Optional (macro SNE_ARB_STATS_EN):
//   stat_clr_i             : clears the per-source beat counters
//   stat_beats_o           : N_SRC x 16 saturating accepted-beat counters
module evt_stream_rr_arbiter
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned QUOTA_W = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_SRC-1:0]          enable_i,
    input  logic                      synch_en_i,
    input  logic [QUOTA_W-1:0]        quota_i,
    input  logic [N_SRC-1:0]          src_valid_i,
    output logic [N_SRC-1:0]          src_ready_o,
    input  logic [N_SRC*DATA_W-1:0]   src_data_i,
    input  logic [N_SRC-1:0]          src_barrier_i,
    output logic                      dst_valid_o,
    input  logic                      dst_ready_i,
    output logic [DATA_W-1:0]         dst_data_o,
    output logic                      dst_barrier_o,
    output logic [$clog2(N_SRC)-1:0]  grant_id_o,
    output logic                      busy_o
`ifdef SNE_ARB_STATS_EN
    ,
    input  logic                      stat_clr_i,
    output logic [N_SRC*16-1:0]       stat_beats_o
`endif
);

    localparam int unsigned IdxW = $clog2(N_SRC);

    arb_state_e          state_q;
    logic [IdxW-1:0]     grant_q;
    logic [IdxW-1:0]     ptr_q;
    logic [QUOTA_W-1:0]  cnt_q;
    logic [N_SRC-1:0]    bseen_q;
    logic [N_SRC-1:0]    bseen_d;
    logic                dst_valid_q;
    logic [DATA_W-1:0]   dst_data_q;
    logic                dst_barrier_q;

    logic                out_free;
    logic [N_SRC-1:0]    bseen_en;
    logic [N_SRC-1:0]    eligible;
    logic                sync_hit;
    logic                grant_active;
    logic                accept;
    logic                consume_barrier;
    logic                load_beat;
    logic                release_grant;
    logic [DATA_W-1:0]   g_data;
    logic                g_barrier;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_found;

    always_comb begin
        out_free = !dst_valid_q || dst_ready_i;
        // Seen bits of disabled sources never count toward the barrier.
        bseen_en = bseen_q & enable_i;
        eligible = src_valid_i & enable_i & ~(synch_en_i ? bseen_en : '0);
        sync_hit = synch_en_i && (enable_i != '0) && (bseen_en == enable_i);

        g_data    = '0;
        g_barrier = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_q == IdxW'(i)) begin
                g_data    = src_data_i[i*DATA_W +: DATA_W];
                g_barrier = src_barrier_i[i];
            end
        end

        grant_active    = (state_q == StGrant) && enable_i[grant_q];
        src_ready_o     = '0;
        if (grant_active && out_free) begin
            src_ready_o[grant_q] = 1'b1;
        end
        accept          = grant_active && out_free && src_valid_i[grant_q];
        consume_barrier = accept && synch_en_i && g_barrier;
        load_beat       = accept && !consume_barrier;

        release_grant = 1'b0;
        if (state_q == StGrant) begin
            if (!enable_i[grant_q] || !src_valid_i[grant_q] || consume_barrier) begin
                release_grant = 1'b1;
            end else if (load_beat && (cnt_q == quota_i)) begin
                release_grant = 1'b1;
            end
        end

        bseen_d = bseen_en;
        if (consume_barrier) begin
            bseen_d[grant_q] = 1'b1;
        end
        if ((state_q == StSyncEmit) && out_free) begin
            bseen_d = '0;
        end
    end

    evt_rr_pick #(
        .N    (N_SRC),
        .IdxW (IdxW)
    ) u_pick (
        .mask_i  (eligible),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            bseen_q       <= '0;
            dst_valid_q   <= 1'b0;
            dst_data_q    <= '0;
            dst_barrier_q <= 1'b0;
        end else begin
            bseen_q <= bseen_d;
            if (out_free) begin
                dst_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    // A completed barrier round wins over new grants.
                    if (sync_hit) begin
                        state_q <= StSyncEmit;
                    end else if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    if (load_beat) begin
                        dst_valid_q   <= 1'b1;
                        dst_data_q    <= g_data;
                        dst_barrier_q <= g_barrier;
                        cnt_q         <= cnt_q + 1'b1;
                    end
                    if (release_grant) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        ptr_q   <= IdxW'(rr_next(32'(grant_q), N_SRC));
                    end
                end
                StSyncEmit: begin
                    if (out_free) begin
                        dst_valid_q   <= 1'b1;
                        dst_data_q    <= '0;
                        dst_barrier_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dst_valid_o   = dst_valid_q;
    assign dst_data_o    = dst_data_q;
    assign dst_barrier_o = dst_barrier_q;
    assign grant_id_o    = grant_q;
    assign busy_o        = (state_q != StIdle) || dst_valid_q;

`ifdef SNE_ARB_STATS_EN
    for (genvar i = 0; i < N_SRC; i++) begin : g_stat
        logic [15:0] beats_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                beats_q <= '0;
            end else if (stat_clr_i) begin
                beats_q <= '0;
            end else if (src_valid_i[i] && src_ready_o[i] && (beats_q != 16'hFFFF)) begin
                beats_q <= beats_q + 16'd1;
            end
        end
        assign stat_beats_o[i*16 +: 16] = beats_q;
    end
`endif

endmodule

// File: tb/tb_evt_stream_rr_arbiter.sv
module tb_evt_stream_rr_arbiter;
    import sne_evt_stream_pkg::*;

    localparam int unsigned N_SRC   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned QUOTA_W = 4;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [N_SRC-1:0]         enable_i;
    logic                     synch_en_i;
    logic [QUOTA_W-1:0]       quota_i;
    logic [N_SRC-1:0]         src_valid_i;
    logic [N_SRC-1:0]         src_ready_o;
    logic [N_SRC*DATA_W-1:0]  src_data_i;
    logic [N_SRC-1:0]         src_barrier_i;
    logic                     dst_valid_o;
    logic                     dst_ready_i;
    logic [DATA_W-1:0]        dst_data_o;
    logic                     dst_barrier_o;
    logic [1:0]               grant_id_o;
    logic                     busy_o;
`ifdef SNE_ARB_STATS_EN
    logic                     stat_clr_i;
    logic [N_SRC*16-1:0]      stat_beats_o;
`endif

    evt_stream_rr_arbiter #(
        .N_SRC   (N_SRC),
        .DATA_W  (DATA_W),
        .QUOTA_W (QUOTA_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .synch_en_i    (synch_en_i),
        .quota_i       (quota_i),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .src_data_i    (src_data_i),
        .src_barrier_i (src_barrier_i),
        .dst_valid_o   (dst_valid_o),
        .dst_ready_i   (dst_ready_i),
        .dst_data_o    (dst_data_o),
        .dst_barrier_o (dst_barrier_o),
        .grant_id_o    (grant_id_o),
        .busy_o        (busy_o)
`ifdef SNE_ARB_STATS_EN
        ,
        .stat_clr_i    (stat_clr_i),
        .stat_beats_o  (stat_beats_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Per-source pending beats {barrier, data} and the scoreboard of expected outputs.
    logic [DATA_W:0] srcq [N_SRC][$];
    logic [DATA_W:0] expq [$];
    int              beat_cyc [$];
    logic [DATA_W:0] mon_exp;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W:0] mk(input int s, input int k, input bit bar);
        logic [3:0]  sid = 4'(s);
        logic [27:0] kid = 28'(k);
        return {bar, sid, kid};
    endfunction

    function automatic int pending();
        int p = expq.size();
        for (int s = 0; s < N_SRC; s++) p += srcq[s].size();
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while (pending() != 0 && n < max) begin
            tick(1);
            n++;
        end
        tick(2);
        check_val(tag, 64'(pending()), 64'd0);
    endtask

    task automatic wait_src_empty(input int s, input string tag);
        int n = 0;
        while (srcq[s].size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        check_val(tag, 64'(srcq[s].size()), 64'd0);
    endtask

    // Source driver: a beat leaves its queue once valid and ready met at a clock edge.
    initial begin
        logic [N_SRC-1:0] fire;
        src_valid_i   = '0;
        src_data_i    = '0;
        src_barrier_i = '0;
        forever begin
            @(negedge clk_i);
            fire = src_valid_i & src_ready_o;
            @(posedge clk_i);
            #1;
            for (int s = 0; s < N_SRC; s++) begin
                if (fire[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
                src_valid_i[s] = (srcq[s].size() > 0);
                if (srcq[s].size() > 0) begin
                    src_data_i[s*DATA_W +: DATA_W] = srcq[s][0][DATA_W-1:0];
                    src_barrier_i[s]               = srcq[s][0][DATA_W];
                end else begin
                    src_barrier_i[s] = 1'b0;
                end
            end
        end
    end

    // Output monitor: every accepted output beat must match the scoreboard head.
    always @(negedge clk_i) begin
        if (rst_ni && dst_valid_o && dst_ready_i) begin
            check_val("sb_has_entry", 64'(expq.size() > 0), 64'd1);
            if (expq.size() > 0) begin
                mon_exp = expq.pop_front();
                check_val("beat", 64'({dst_barrier_o, dst_data_o}), 64'(mon_exp));
            end
            beat_cyc.push_back(cyc);
        end
    end

    initial begin
        int n;
        int c;
        rst_ni      = 1'b0;
        enable_i    = '0;
        synch_en_i  = 1'b0;
        quota_i     = '0;
        dst_ready_i = 1'b1;
`ifdef SNE_ARB_STATS_EN
        stat_clr_i  = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_dst_valid", 64'(dst_valid_o), 64'd0);
        check_val("rst_dst_data", 64'(dst_data_o), 64'd0);
        check_val("rst_dst_barrier", 64'(dst_barrier_o), 64'd0);
        check_val("rst_src_ready", 64'(src_ready_o), 64'd0);
        check_val("rst_grant_id", 64'(grant_id_o), 64'd0);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        tick(1);
        rst_ni = 1'b1;
        tick(2);

        // Quota 0, all sources valid: one beat per grant, order 0,1,2,3,0,..., one bubble.
        enable_i = 4'hF;
        quota_i  = '0;
        beat_cyc.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N_SRC; s++) begin
                srcq[s].push_back(mk(s, r, 1'b0));
                expq.push_back(mk(s, r, 1'b0));
            end
        wait_drain("t1_drain", 60);
        check_val("t1_beats", 64'(beat_cyc.size()), 64'd8);
        for (int k = 1; k < beat_cyc.size(); k++)
            check_val("t1_gap", 64'(beat_cyc[k] - beat_cyc[k-1]), 64'd2);

        // Quota 3, source 2 alone with 10 beats: bursts 4,4,2 separated by one idle cycle.
        quota_i = QUOTA_W'(DefaultQuota);
        beat_cyc.delete();
        for (int k = 0; k < 10; k++) begin
            srcq[2].push_back(mk(2, 16 + k, 1'b0));
            expq.push_back(mk(2, 16 + k, 1'b0));
        end
        wait_drain("t2_drain", 60);
        check_val("t2_beats", 64'(beat_cyc.size()), 64'd10);
        for (int k = 1; k < beat_cyc.size(); k++)
            check_val("t2_gap", 64'(beat_cyc[k] - beat_cyc[k-1]), (k % 4 == 0) ? 64'd2 : 64'd1);

        // Five-cycle backpressure mid-burst.
        quota_i = 4'd7;
        beat_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            srcq[1].push_back(mk(1, 32 + k, 1'b0));
            expq.push_back(mk(1, 32 + k, 1'b0));
        end
        n = 0;
        while (beat_cyc.size() < 3 && n < 40) begin
            tick(1);
            n++;
        end
        dst_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check_val("t3_hold_valid", 64'(dst_valid_o), 64'd1);
            check_val("t3_hold_data", 64'({dst_barrier_o, dst_data_o}), 64'(expq[0]));
            check_val("t3_src_ready", 64'(src_ready_o), 64'd0);
            tick(1);
        end
        dst_ready_i = 1'b1;
        wait_drain("t3_drain", 60);
        check_val("t3_beats", 64'(beat_cyc.size()), 64'd8);

        // All sources disabled: nothing is granted.
        enable_i = '0;
        beat_cyc.delete();
        srcq[0].push_back(mk(0, 48, 1'b0));
        tick(8);
        check_val("t4_src_ready", 64'(src_ready_o), 64'd0);
        check_val("t4_busy", 64'(busy_o), 64'd0);
        check_val("t4_no_beat", 64'(beat_cyc.size()), 64'd0);
        srcq[0].delete();
        tick(2);

        // Barrier forwarded as an ordinary beat when merging is off.
        enable_i = 4'hF;
        quota_i  = '0;
        srcq[3].push_back(mk(3, 49, 1'b1));
        expq.push_back(mk(3, 49, 1'b1));
        wait_drain("t5_drain", 30);

        // Barrier merge: barriers from 1,0,2 give one zero-data barrier beat.
        synch_en_i = 1'b1;
        enable_i   = 4'b0111;
        beat_cyc.delete();
        expq.push_back({1'b1, 32'h0});
        srcq[1].push_back(mk(1, 50, 1'b1));
        wait_src_empty(1, "t6_bar1");
        srcq[0].push_back(mk(0, 51, 1'b1));
        wait_src_empty(0, "t6_bar0");
        check_val("t6_no_early_emit", 64'(beat_cyc.size()), 64'd0);
        srcq[2].push_back(mk(2, 52, 1'b1));
        wait_drain("t6_drain", 30);
        check_val("t6_one_emit", 64'(beat_cyc.size()), 64'd1);
        for (int s = 0; s < 3; s++) begin
            srcq[s].push_back(mk(s, 60, 1'b0));
            expq.push_back(mk(s, 60, 1'b0));
        end
        wait_drain("t6_reeligible", 40);

        // Two sources parked, then enable shrinks to them: emit on the next idle cycle.
        beat_cyc.delete();
        srcq[0].push_back(mk(0, 70, 1'b1));
        wait_src_empty(0, "t7_bar0");
        srcq[1].push_back(mk(1, 71, 1'b1));
        wait_src_empty(1, "t7_bar1");
        tick(5);
        check_val("t7_no_emit", 64'(beat_cyc.size()), 64'd0);
        enable_i = 4'b0011;
        c = cyc;
        expq.push_back({1'b1, 32'h0});
        wait_drain("t7_drain", 30);
        check_val("t7_emit_cyc", 64'((beat_cyc.size() > 0) ? beat_cyc[0] : 0), 64'(c + 2));
        synch_en_i = 1'b0;

        // Reset with a beat stuck in the output register: it must vanish.
        enable_i    = 4'hF;
        dst_ready_i = 1'b0;
        srcq[3].push_back(mk(3, 80, 1'b0));
        expq.push_back(mk(3, 80, 1'b0));
        n = 0;
        while (!dst_valid_o && n < 20) begin
            tick(1);
            n++;
        end
        check_val("t8_pre_valid", 64'(dst_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_val("t8_rst_valid", 64'(dst_valid_o), 64'd0);
        check_val("t8_rst_data", 64'(dst_data_o), 64'd0);
        check_val("t8_rst_busy", 64'(busy_o), 64'd0);
        for (int s = 0; s < N_SRC; s++) srcq[s].delete();
        expq.delete();
        tick(2);
        rst_ni      = 1'b1;
        dst_ready_i = 1'b1;
        beat_cyc.delete();
        tick(10);
        check_val("t8_no_replay", 64'(beat_cyc.size()), 64'd0);

`ifdef SNE_ARB_STATS_EN
        // Counter saturation and clear.
        quota_i = 4'hF;
        for (int k = 0; k < 70000; k++) begin
            srcq[3].push_back(mk(3, k, 1'b0));
            expq.push_back(mk(3, k, 1'b0));
        end
        wait_drain("t9_drain", 80000);
        check_val("t9_stat_sat", 64'(stat_beats_o[3*16 +: 16]), 64'hFFFF);
        stat_clr_i = 1'b1;
        tick(1);
        stat_clr_i = 1'b0;
        check_val("t9_stat_clr", 64'(stat_beats_o[3*16 +: 16]), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
